// File: rtl/doc_mix_pkg.sv
// doc_mix_pkg: shared FSM state type and constants for the DOC channel mixer
package doc_mix_pkg;
  typedef enum logic [1:0] {ACCUM, SCALE, EMIT} state_e;
  localparam int CA_W = 4;
  localparam logic [7:0] VOL_UNITY = 8'h80;
endpackage

// File: rtl/doc_mix_sat.sv
// doc_mix_sat: combinational signed clamp from IN_W to OUT_W bits
// din (signed IN_W) -> dout (signed OUT_W), clamped to +max/-min, never wrapped
module doc_mix_sat #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);
  if (IN_W > OUT_W) begin : g_clamp
    logic fits;
    assign fits = &din[IN_W-1:OUT_W-1] || ~|din[IN_W-1:OUT_W-1];
    assign dout = fits ? din[OUT_W-1:0] : din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end else begin : g_ext
    assign dout = OUT_W'(din);
  end
endmodule

// File: rtl/doc_channel_mixer.sv
// doc_channel_mixer: steers es5503 oscillator samples into NUM_CH saturating accumulators, emits one scaled sample per channel per DOC frame
// In: CLK_14M, reset (async), osc_strobe/osc_sample/osc_ca, frame_end, vol_wr/vol_addr/vol_data.
// Out: mix_out (channel c at [c*OUT_W +: OUT_W]), out_strobe, overflow (sticky).
// Define MIXER_VOLUME_EN for per-channel volume (one extra pipeline cycle in SCALE).
module doc_channel_mixer
  import doc_mix_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IN_W   = 16,
  parameter int ACC_W  = 20,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 4
) (
  input  logic                    CLK_14M,
  input  logic                    reset,
  input  logic                    osc_strobe,
  input  logic [IN_W-1:0]         osc_sample,
  input  logic [CA_W-1:0]         osc_ca,
  input  logic                    frame_end,
  input  logic                    vol_wr,
  input  logic [CA_W-1:0]         vol_addr,
  input  logic [7:0]              vol_data,
  output logic [NUM_CH*OUT_W-1:0] mix_out,
  output logic                    out_strobe,
  output logic                    overflow
);
`ifdef MIXER_VOLUME_EN
  localparam int VL = 1;
  localparam int PW = ACC_W + 9;
`else
  localparam int VL = 0;
  localparam int PW = ACC_W;
`endif
  localparam int IW = $clog2(NUM_CH + 1);
  localparam int SW = ACC_W + 2;
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q [NUM_CH];
  logic signed [ACC_W-1:0] acc_d [NUM_CH];
  logic signed [ACC_W-1:0] acc_sum [NUM_CH];
  logic signed [OUT_W-1:0] shadow_q [NUM_CH];
  logic signed [OUT_W-1:0] shadow_d [NUM_CH];
  logic [NUM_CH*OUT_W-1:0] mix_q, mix_d;
  logic strobe_q, strobe_d, ovf_q, ovf_d, pend_v_q, pend_v_d;
  logic signed [IN_W-1:0] pend_s_q, pend_s_d;
  logic [CA_W-1:0] pend_ca_q, pend_ca_d;
  logic osc_ok;
  logic signed [ACC_W-1:0] acc_sel;
  logic signed [PW-1:0] scaled;
  logic signed [OUT_W-1:0] res;
  assign osc_ok = osc_strobe && ({1'b0, osc_ca} < (CA_W+1)'(NUM_CH));
  // pending entry and fresh sample are summed wide, then clamped once
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [SW-1:0] sum;
    assign sum = SW'(acc_q[c])
               + ((pend_v_q && pend_ca_q == CA_W'(c)) ? SW'(pend_s_q) : '0)
               + ((osc_ok && osc_ca == CA_W'(c)) ? SW'(signed'(osc_sample)) : '0);
    doc_mix_sat #(.IN_W(SW), .OUT_W(ACC_W)) u_acc_sat (.din(sum), .dout(acc_sum[c]));
  end
  always_comb begin
    acc_sel = '0;
    for (int i = 0; i < NUM_CH; i++) if (idx_q == IW'(i)) acc_sel = acc_q[i];
  end
`ifdef MIXER_VOLUME_EN
  logic [7:0] vol_q [NUM_CH];
  logic [7:0] vol_d [NUM_CH];
  logic [7:0] vol_sel;
  logic signed [PW-1:0] prod_q, prod_d;
  always_comb begin
    vol_d = vol_q;
    vol_sel = VOL_UNITY;
    for (int i = 0; i < NUM_CH; i++) begin
      if (vol_wr && vol_addr == CA_W'(i)) vol_d[i] = vol_data;
      if (idx_q == IW'(i)) vol_sel = vol_q[i];
    end
    prod_d = PW'(acc_sel) * PW'(signed'({1'b0, vol_sel}));
  end
  always_ff @(posedge CLK_14M or posedge reset) begin
    if (reset) begin
      vol_q  <= '{default: VOL_UNITY};
      prod_q <= '0;
    end else begin
      vol_q  <= vol_d;
      prod_q <= prod_d;
    end
  end
  assign scaled = (prod_q >>> 7) >>> SHIFT;
`else
  logic unused_vol;
  assign unused_vol = ^{vol_wr, vol_addr, vol_data};
  assign scaled = acc_sel >>> SHIFT;
`endif
  doc_mix_sat #(.IN_W(PW), .OUT_W(OUT_W)) u_out_sat (.din(scaled), .dout(res));
  // with volume, the result produced at idx belongs to channel idx-1
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    shadow_d  = shadow_q;
    mix_d     = mix_q;
    strobe_d  = 1'b0;
    ovf_d     = ovf_q;
    pend_v_d  = pend_v_q;
    pend_s_d  = pend_s_q;
    pend_ca_d = pend_ca_q;
    if (state_q == ACCUM) begin
      acc_d    = acc_sum;
      pend_v_d = 1'b0;
      if (frame_end) begin
        state_d = SCALE;
        idx_d   = '0;
      end
    end else begin
      if (osc_ok) begin
        ovf_d     = ovf_q | pend_v_q;
        pend_v_d  = 1'b1;
        pend_s_d  = pend_v_q ? pend_s_q : signed'(osc_sample);
        pend_ca_d = pend_v_q ? pend_ca_q : osc_ca;
      end
      if (frame_end) ovf_d = 1'b1;
      if (state_q == SCALE) begin
        for (int i = 0; i < NUM_CH; i++) if (idx_q == IW'(i + VL)) shadow_d[i] = res;
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(NUM_CH - 1 + VL)) begin
          state_d  = EMIT;
          strobe_d = 1'b1;
          for (int i = 0; i < NUM_CH; i++) mix_d[i*OUT_W +: OUT_W] = (idx_q == IW'(i + VL)) ? res : shadow_q[i];
        end
      end else begin
        state_d = ACCUM;
        acc_d   = '{default: '0};
      end
    end
  end
  always_ff @(posedge CLK_14M or posedge reset) begin
    if (reset) begin
      state_q   <= ACCUM;
      idx_q     <= '0;
      acc_q     <= '{default: '0};
      shadow_q  <= '{default: '0};
      mix_q     <= '0;
      strobe_q  <= 1'b0;
      ovf_q     <= 1'b0;
      pend_v_q  <= 1'b0;
      pend_s_q  <= '0;
      pend_ca_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      shadow_q  <= shadow_d;
      mix_q     <= mix_d;
      strobe_q  <= strobe_d;
      ovf_q     <= ovf_d;
      pend_v_q  <= pend_v_d;
      pend_s_q  <= pend_s_d;
      pend_ca_q <= pend_ca_d;
    end
  end
  assign mix_out    = mix_q;
  assign out_strobe = strobe_q;
  assign overflow   = ovf_q;
endmodule
